// File: rtl/instr_pkg.sv
// Shared definitions for the instruction scheduler: instruction field
// positions, legal opcodes, register codes and the FSM state encoding.
package instr_pkg;

    // Instruction layout {opcode[10:8], Rx[7:4], Ry/imm[3:0]}
    localparam int OPC_HI = 10;
    localparam int OPC_LO = 8;
    localparam int RX_HI  = 7;
    localparam int RX_LO  = 4;
    localparam int RY_HI  = 3;
    localparam int RY_LO  = 0;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;

    localparam logic [3:0] R1 = 4'b0001;
    localparam logic [3:0] R2 = 4'b0010;
    localparam logic [3:0] R3 = 4'b0011;
    localparam logic [3:0] R4 = 4'b0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMPLETE,
        ST_REJECT
    } state_e;

    // Only the four datapath operations reach the control circuit.
    function automatic logic is_legal_opc(input logic [2:0] opc);
        return (opc == OP_LOAD) || (opc == OP_MOV) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/instr_scheduler_if.sv
// Handshake bundle between the scheduler, its two requesters and the
// control circuit. master = requester/control-circuit side, slave = scheduler.
interface instr_scheduler_if #(
    parameter int INSTR_W = 11,
    parameter int CNT_W   = 8
);
    logic               req0_valid;
    logic [INSTR_W-1:0] req0_instr;
    logic               req0_ready;
    logic               req1_valid;
    logic [INSTR_W-1:0] req1_instr;
    logic               req1_ready;
    logic [INSTR_W-1:0] cc_instruction;
    logic               cc_valid;
    logic               cc_done;
    logic               resp_valid;
    logic               resp_id;
    logic               resp_err;
    logic               busy;
    logic [CNT_W-1:0]   exec_count;

    modport master (
        output req0_valid, req0_instr, req1_valid, req1_instr, cc_done,
        input  req0_ready, req1_ready, cc_instruction, cc_valid,
               resp_valid, resp_id, resp_err, busy, exec_count
    );

    modport slave (
        input  req0_valid, req0_instr, req1_valid, req1_instr, cc_done,
        output req0_ready, req1_ready, cc_instruction, cc_valid,
               resp_valid, resp_id, resp_err, busy, exec_count
    );
endinterface

// File: rtl/instr_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: on contention the requester that did not
// win last time is chosen; a lone requester always wins.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);
    // Pure combinational pick, no state here (history lives in the top).
    always_comb begin
        grant_valid = |valid;
        grant       = (valid == 2'b11) ? ~last_grant : valid[1];
    end
endmodule

// File: rtl/instr_scheduler.sv
// Shares one control circuit between two instruction requesters.
// Optional feature: define WATCHDOG_EN to bound the wait for cc_done to
// TIMEOUT_CYCLES cycles (timed-out instructions complete with resp_err=1).
module instr_scheduler
    import instr_pkg::*;
#(
    parameter int INSTR_W = 11,
    parameter int OPC_W   = 3,
    parameter int CNT_W   = 8
`ifdef WATCHDOG_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input logic              clk,
    input logic              reset,
    instr_scheduler_if.slave bus
);

    state_e             state;
    logic               last_grant;
    logic               grant;
    logic               grant_valid;
    logic               xfer;
    logic [INSTR_W-1:0] sel_instr;
    logic [OPC_W-1:0]   sel_opc;
    logic [INSTR_W-1:0] instr_q;
    logic               cc_valid_q;
    logic               resp_valid_q;
    logic               resp_id_q;
    logic               resp_err_q;
    logic               busy_q;
    logic [CNT_W-1:0]   exec_count_q;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    rr_arbiter2 u_arb (
        .valid       ({bus.req1_valid, bus.req0_valid}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign sel_instr = grant ? bus.req1_instr : bus.req0_instr;
    assign sel_opc   = sel_instr[INSTR_W-1 -: OPC_W];
    // Ready is only offered in IDLE, so a transfer is simply IDLE plus a winner.
    assign xfer           = (state == ST_IDLE) && grant_valid;
    assign bus.req0_ready = xfer && !grant;
    assign bus.req1_ready = xfer && grant;

    assign bus.cc_instruction = instr_q;
    assign bus.cc_valid       = cc_valid_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_id        = resp_id_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.busy           = busy_q;
    assign bus.exec_count     = exec_count_q;

    // Scheduler FSM; pulse outputs are set on the transition into the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            instr_q      <= '0;
            cc_valid_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            exec_count_q <= '0;
`ifdef WATCHDOG_EN
            wd_cnt       <= '0;
`endif
        end else begin
            cc_valid_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        instr_q    <= sel_instr;
                        resp_id_q  <= grant;
                        last_grant <= grant;
                        busy_q     <= 1'b1;
`ifdef WATCHDOG_EN
                        wd_cnt     <= '0;
`endif
                        if (is_legal_opc(sel_opc)) begin
                            state      <= ST_ISSUE;
                            cc_valid_q <= 1'b1;
                        end else begin
                            state        <= ST_REJECT;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (bus.cc_done) begin
                        state        <= ST_COMPLETE;
                        resp_valid_q <= 1'b1;
                        exec_count_q <= exec_count_q + CNT_W'(1);
`ifdef WATCHDOG_EN
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state        <= ST_COMPLETE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        state  <= ST_WAIT;
`else
                    end else begin
                        state <= ST_WAIT;
`endif
                    end
                end
                ST_COMPLETE, ST_REJECT: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
